// File: rtl/cond_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cond_exec_ctrl
//   Execute-stage conditional-execution controller. Owns the architectural
//   NZCV register and evaluates the E-stage condition field against it. It
//   gates the RegWrite/MemWrite/PCSrc side effects of the E-stage
//   instruction, and it sequences the post-branch squash window that drives
//   the hazard unit's F/D flush.
//
//   Optional feature: define COND_EXEC_STATS_EN to add the ExecCnt/SkipCnt
//   saturating statistics outputs.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   StallE        E stage held, no state advances
//   FlushE        external squash of the current E instruction
//   ValidE        E stage holds a real instruction
//   CondE[3:0]    ARM condition field
//   FlagWriteE    [1] update N,Z ; [0] update C,V
//   ALUFlags      {N,Z,C,V} produced by the ALU this cycle
//   RegWriteE, MemWriteE, PCSrcE   requested side effects
//   Flags         current NZCV register
//   CondExE       condition passed and instruction live
//   RegWriteGE, MemWriteGE, PCSrcGE   gated side effects (combinational)
//   BranchFlush   squash F/D stages
//   ExecCnt, SkipCnt (COND_EXEC_STATS_EN only) executed / skipped counters
// ---------------------------------------------------------------------------
module cond_exec_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        ValidE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWriteE,
    input  logic [3:0]  ALUFlags,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        PCSrcE,
    output logic [3:0]  Flags,
    output logic        CondExE,
    output logic        RegWriteGE,
    output logic        MemWriteGE,
    output logic        PCSrcGE,
`ifdef COND_EXEC_STATS_EN
    output logic [15:0] ExecCnt,
    output logic [15:0] SkipCnt,
`endif
    output logic        BranchFlush
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;
    logic live;
    logic cond_ex;
    logic pcsrc_g;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Condition decode on the registered flags only; 1111 decodes to fail.
    always_comb begin
        cond_pass = 1'b0;
        unique case (CondE)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~(flag_c & ~flag_z);
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = ~(~flag_z & (flag_n == flag_v));
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // An instruction is dead while reset is high, when squashed, or in FLUSH.
    assign live    = ValidE & ~FlushE & (state_q == ST_RUN) & ~reset;
    assign cond_ex = live & cond_pass;
    assign pcsrc_g = PCSrcE & cond_ex;

    assign CondExE     = cond_ex;
    assign RegWriteGE  = RegWriteE & cond_ex;
    assign MemWriteGE  = MemWriteE & cond_ex;
    assign PCSrcGE     = pcsrc_g;
    assign BranchFlush = ~reset & (pcsrc_g | (state_q == ST_FLUSH));
    assign Flags       = reset ? FLAG_W'(0) : flags_q;

    // Next-state: flag merge and squash-window sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flags_d = flags_q;

        if (cond_ex && !StallE) begin
            if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
        end

        if (!StallE) begin
            unique case (state_q)
                ST_RUN: begin
                    if (pcsrc_g) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

`ifdef COND_EXEC_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [STAT_W-1:0] skip_cnt_q, skip_cnt_d;

    // Saturating counters, advanced on unstalled edges only.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (!StallE) begin
            if (cond_ex && (exec_cnt_q != '1))
                exec_cnt_d = exec_cnt_q + STAT_W'(1);
            if (ValidE && !cond_ex && (skip_cnt_q != '1))
                skip_cnt_d = skip_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign ExecCnt = reset ? STAT_W'(0) : exec_cnt_q;
    assign SkipCnt = reset ? STAT_W'(0) : skip_cnt_q;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_ctrl
//   Directed self-checking bench for cond_exec_ctrl (FLUSH_CYCLES = 2).
//   Inputs change 1 time unit after a rising edge; outputs are checked
//   before the next rising edge.
// ---------------------------------------------------------------------------
module tb_cond_exec_ctrl;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_NE = 4'b0001;
    localparam logic [3:0] C_HI = 4'b1000;
    localparam logic [3:0] C_GE = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_AL = 4'b1110;
    localparam logic [3:0] C_NV = 4'b1111;

    logic        clk;
    logic        reset;
    logic        StallE, FlushE, ValidE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [3:0]  ALUFlags;
    logic        RegWriteE, MemWriteE, PCSrcE;
    logic [3:0]  Flags;
    logic        CondExE, RegWriteGE, MemWriteGE, PCSrcGE, BranchFlush;
`ifdef COND_EXEC_STATS_EN
    logic [15:0] ExecCnt, SkipCnt;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    cond_exec_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .StallE     (StallE),
        .FlushE     (FlushE),
        .ValidE     (ValidE),
        .CondE      (CondE),
        .FlagWriteE (FlagWriteE),
        .ALUFlags   (ALUFlags),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .PCSrcE     (PCSrcE),
        .Flags      (Flags),
        .CondExE    (CondExE),
        .RegWriteGE (RegWriteGE),
        .MemWriteGE (MemWriteGE),
        .PCSrcGE    (PCSrcGE),
`ifdef COND_EXEC_STATS_EN
        .ExecCnt    (ExecCnt),
        .SkipCnt    (SkipCnt),
`endif
        .BranchFlush(BranchFlush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply a full E-stage input vector and let combinational outputs settle.
    task automatic apply(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic [3:0] af, input logic rw, input logic mw,
                         input logic pc, input logic st, input logic fl);
        ValidE     = v;
        CondE      = c;
        FlagWriteE = fw;
        ALUFlags   = af;
        RegWriteE  = rw;
        MemWriteE  = mw;
        PCSrcE     = pc;
        StallE     = st;
        FlushE     = fl;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;

        // Reset: a live-looking branch must produce nothing.
        apply(1'b1, C_AL, 2'b11, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        chk("rst_condex",  16'(CondExE),     16'h0);
        chk("rst_bflush",  16'(BranchFlush), 16'h0);
        chk("rst_pcsrc",   16'(PCSrcGE),     16'h0);
        chk("rst_regwr",   16'(RegWriteGE),  16'h0);
        chk("rst_flags",   16'(Flags),       16'h0);
        cyc();
        reset = 1'b0;

        // 1: CMP-like AL sets Z; following EQ writes a register.
        apply(1'b1, C_AL, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_cmp_condex", 16'(CondExE), 16'h1);
        chk("t1_flags_same_cycle", 16'(Flags), 16'h0);
        cyc();
        chk("t1_flags", 16'(Flags), 16'h4);
        apply(1'b1, C_EQ, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_eq_regwr", 16'(RegWriteGE), 16'h1);

        // 2: NE fails with Z=1; no store, no flag update.
        cyc();
        apply(1'b1, C_NE, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ne_memwr",  16'(MemWriteGE), 16'h0);
        chk("t2_ne_condex", 16'(CondExE),    16'h0);
        cyc();
        chk("t2_flags_hold", 16'(Flags), 16'h4);

        // Stalled flag-setter must not update flags.
        apply(1'b1, C_AL, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_condex", 16'(CondExE), 16'h1);
        cyc();
        chk("stall_flags_hold", 16'(Flags), 16'h4);

        // 3: clear flags, then CV-only update, then LT/GE/HI/NV.
        apply(1'b1, C_AL, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("t3_flags_clear", 16'(Flags), 16'h0);
        apply(1'b1, C_AL, 2'b01, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("t3_flags_cv", 16'(Flags), 16'h3);
        apply(1'b1, C_LT, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_lt", 16'(CondExE), 16'h1);
        apply(1'b1, C_GE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_ge", 16'(CondExE), 16'h0);
        apply(1'b1, C_HI, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_hi", 16'(CondExE), 16'h1);
        apply(1'b1, C_NV, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_nv", 16'(CondExE), 16'h0);
        apply(1'b0, C_AL, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("invalid_regwr", 16'(RegWriteGE), 16'h0);

        // 4: taken branch, two squash cycles, PCSrcE ignored in FLUSH.
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_pcsrc",  16'(PCSrcGE),     16'h1);
        chk("t4_bf0",    16'(BranchFlush), 16'h1);
        cyc();
        apply(1'b1, C_AL, 2'b11, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_bf1",     16'(BranchFlush), 16'h1);
        chk("t4_sq_regwr", 16'(RegWriteGE), 16'h0);
        chk("t4_sq_condex", 16'(CondExE),   16'h0);
        cyc();
        chk("t4_flags_hold1", 16'(Flags), 16'h3);
        apply(1'b1, C_AL, 2'b11, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_bf2",      16'(BranchFlush), 16'h1);
        chk("t4_sq_pcsrc", 16'(PCSrcGE),     16'h0);
        cyc();
        chk("t4_flags_hold2", 16'(Flags), 16'h3);
        idle();
        chk("t4_bf_end", 16'(BranchFlush), 16'h0);

        // 5: branch stalled for 3 cycles, then 3 unstalled flush cycles.
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5_stall_bf%0d", i), 16'(BranchFlush), 16'h1);
            chk($sformatf("t5_stall_pc%0d", i), 16'(PCSrcGE),     16'h1);
            cyc();
        end
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_bf_br", 16'(BranchFlush), 16'h1);
        cyc();
        idle();
        chk("t5_bf_f1", 16'(BranchFlush), 16'h1);
        cyc();
        chk("t5_bf_f2", 16'(BranchFlush), 16'h1);
        cyc();
        chk("t5_bf_end", 16'(BranchFlush), 16'h0);

        // FlushE wins over a same-cycle branch.
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t5_fl_pcsrc", 16'(PCSrcGE),     16'h0);
        chk("t5_fl_bf",    16'(BranchFlush), 16'h0);
        cyc();
        idle();
        chk("t5_fl_bf_next", 16'(BranchFlush), 16'h0);

        // 6: reset during FLUSH.
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        idle();
        chk("t6_in_flush", 16'(BranchFlush), 16'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_bf", 16'(BranchFlush), 16'h0);
        cyc();
        reset = 1'b0;
        #1;
        chk("t6_post_bf",    16'(BranchFlush), 16'h0);
        chk("t6_post_flags", 16'(Flags),       16'h0);

        // 3 executed, then cond-fail and FlushE skips (Z=0 so EQ fails).
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cyc();
        end
        apply(1'b1, C_EQ, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_eq_fail", 16'(CondExE), 16'h0);
        cyc();
        apply(1'b1, C_AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_flushe", 16'(CondExE), 16'h0);
        cyc();
        idle();
        cyc();
`ifdef COND_EXEC_STATS_EN
        chk("stats_exec", ExecCnt, 16'd3);
        chk("stats_skip", SkipCnt, 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
